// File: rtl/fb_scanout.sv
// Read-side framebuffer master in the pixel clock domain. It generates VGA timing and 2^SCALE_SHIFT-upscaled read
// addresses, and presents RGB/DE/syncs three clocks after the counters. Define SCANOUT_TEST_PATTERN_EN for colour bars.
module fb_scanout #(
    parameter int ADDR_WIDTH  = 17,
    parameter int DATA_WIDTH  = 24,
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int SCALE_SHIFT = 1,
    parameter bit SYNC_POL    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
`ifdef SCANOUT_TEST_PATTERN_EN
    input  logic                  test_mode,
`endif
    output logic                  fb_en_rd,
    output logic [ADDR_WIDTH-1:0] fb_addr_rd,
    input  logic [DATA_WIDTH-1:0] fb_dout,
    output logic [DATA_WIDTH-1:0] vid_rgb,
    output logic                  vid_de,
    output logic                  vid_hsync,
    output logic                  vid_vsync,
    output logic                  frame_start
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int SRC_W    = H_ACTIVE >> SCALE_SHIFT;
    localparam int SRC_H    = V_ACTIVE >> SCALE_SHIFT;
    localparam int SRC_MASK = (1 << SCALE_SHIFT) - 1;
    localparam int H_W      = $clog2(H_TOTAL);
    localparam int V_W      = $clog2(V_TOTAL);

    if (longint'(SRC_W) * longint'(SRC_H) > (longint'(1) << ADDR_WIDTH)) begin : g_addr_check
        $error("fb_scanout: source image does not fit in ADDR_WIDTH");
    end

    logic [H_W-1:0]        h;
    logic [V_W-1:0]        v;
    logic [ADDR_WIDTH-1:0] line_base;
    logic [ADDR_WIDTH-1:0] addr0;
    logic                  h_last, v_last, active0, hs0, vs0, fs0, src_step, rd0;
    logic                  de1, hs1, vs1, fs1;
    logic                  de2, hs2, vs2, fs2;
    logic                  clear;

`ifdef SCANOUT_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;
    logic [H_W-1:0]        bar_cnt;
    logic [2:0]            bar_idx;
    logic [23:0]           bar_rgb;
    logic [DATA_WIDTH-1:0] pat1, pat2;
    logic                  tm0, tm_q, tm1, tm2;
`endif

    assign clear = rst || !enable;

    // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
    always_comb begin
        h_last   = (32'(h) == H_TOTAL - 1);
        v_last   = (32'(v) == V_TOTAL - 1);
        active0  = (32'(h) < H_ACTIVE) && (32'(v) < V_ACTIVE);
        hs0      = (32'(h) >= HS_START) && (32'(h) < HS_END);
        vs0      = (32'(v) >= VS_START) && (32'(v) < VS_END);
        fs0      = (h == '0) && (v == '0);
        // The next line starts a new source line only on a scale boundary inside the active area.
        src_step = (((32'(v) + 1) & SRC_MASK) == 0) && (32'(v) + 1 < V_ACTIVE);
        addr0    = line_base + ADDR_WIDTH'(h >> SCALE_SHIFT);
`ifdef SCANOUT_TEST_PATTERN_EN
        tm0      = fs0 ? test_mode : tm_q;
        rd0      = active0 && !tm0;
        bar_rgb  = 24'h000000;
        case (bar_idx)
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'hFFFF00;
            3'd2:    bar_rgb = 24'h00FFFF;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'hFF0000;
            3'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
`else
        rd0      = active0;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clear) begin
            h           <= '0;
            v           <= '0;
            line_base   <= '0;
            fb_en_rd    <= 1'b0;
            fb_addr_rd  <= '0;
            {de1, hs1, vs1, fs1} <= '0;
            {de2, hs2, vs2, fs2} <= '0;
            vid_rgb     <= '0;
            vid_de      <= 1'b0;
            vid_hsync   <= !SYNC_POL;
            vid_vsync   <= !SYNC_POL;
            frame_start <= 1'b0;
        end else begin
            h <= h_last ? '0 : h + 1'b1;
            if (h_last) begin
                v <= v_last ? '0 : v + 1'b1;
                if (v_last)
                    line_base <= '0;
                else if (src_step)
                    line_base <= line_base + ADDR_WIDTH'(SRC_W);
            end
            fb_en_rd <= rd0;
            if (rd0)
                fb_addr_rd <= addr0;
            {de1, hs1, vs1, fs1} <= {active0, hs0, vs0, fs0};
            {de2, hs2, vs2, fs2} <= {de1, hs1, vs1, fs1};
`ifdef SCANOUT_TEST_PATTERN_EN
            vid_rgb <= !de2 ? '0 : (tm2 ? pat2 : fb_dout);
`else
            vid_rgb <= de2 ? fb_dout : '0;
`endif
            vid_de      <= de2;
            vid_hsync   <= hs2 ? SYNC_POL : !SYNC_POL;
            vid_vsync   <= vs2 ? SYNC_POL : !SYNC_POL;
            frame_start <= fs2;
        end
    end

`ifdef SCANOUT_TEST_PATTERN_EN
    // Bar position is tracked incrementally to avoid dividing h by the bar width.
    always_ff @(posedge clk) begin
        if (clear) begin
            bar_cnt <= '0;
            bar_idx <= '0;
            tm_q    <= 1'b0;
            {tm1, tm2}   <= '0;
            {pat1, pat2} <= '0;
        end else begin
            if (h_last) begin
                bar_cnt <= '0;
                bar_idx <= '0;
            end else if (32'(bar_cnt) == BAR_W - 1) begin
                bar_cnt <= '0;
                bar_idx <= bar_idx + 1'b1;
            end else begin
                bar_cnt <= bar_cnt + 1'b1;
            end
            tm_q <= tm0;
            tm1  <= tm0;
            tm2  <= tm1;
            pat1 <= DATA_WIDTH'(bar_rgb);
            pat2 <= pat1;
        end
    end
`endif

endmodule
